// File: rtl/rv32_instr_encoder.sv
// RV32I request-to-machine-word encoder with a 2-entry address-tagged
// output buffer and illegal-request reporting.
module rv32_instr_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam logic [1:0] KIND_R  = 2'b00;
    localparam logic [1:0] KIND_I  = 2'b01;
    localparam logic [1:0] KIND_LD = 2'b10;
    localparam logic [1:0] KIND_ST = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [11:0]       imm_i;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              ld_head;
    logic              ld_tail;
    logic              shift;

    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       tail_instr;
    logic [ADDR_W-1:0] tail_addr;
    logic [ADDR_W-1:0] addr_cnt;

    always_comb begin
        f3 = 3'b000;
        case (in_alu_op)
            OP_ADD, OP_SUB: f3 = 3'b000;
            OP_SLL:         f3 = 3'b001;
            OP_SLT:         f3 = 3'b010;
            OP_SLTU:        f3 = 3'b011;
            OP_XOR:         f3 = 3'b100;
            OP_SRL, OP_SRA: f3 = 3'b101;
            OP_OR:          f3 = 3'b110;
            OP_AND:         f3 = 3'b111;
            default:        f3 = 3'b000;
        endcase
    end

    assign f7 = (in_alu_op == OP_SUB || in_alu_op == OP_SRA) ?
                7'b0100000 : 7'b0000000;

    // Shift-immediates carry shamt only; the upper bits select SRA.
    always_comb begin
        imm_i = in_imm;
        if (in_alu_op == OP_SLL || in_alu_op == OP_SRL)
            imm_i = {7'b0000000, in_imm[4:0]};
        else if (in_alu_op == OP_SRA)
            imm_i = {7'b0100000, in_imm[4:0]};
    end

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_kind)
            KIND_R: begin
                legal = (in_alu_op <= OP_SLTU);
                word  = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            end
            KIND_I: begin
                legal = (in_alu_op <= OP_SLTU) && (in_alu_op != OP_SUB);
                word  = {imm_i, in_rs1, f3, in_rd, 7'b0010011};
            end
            KIND_LD: begin
                word = {in_imm, in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            KIND_ST: begin
                word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                        in_imm[4:0], 7'b0100011};
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign in_ready  = rst_n && !clear && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_instr = head_instr;
    assign out_addr  = head_addr;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready && !clear;

    always_comb begin
        state_nxt = state;
        ld_head   = 1'b0;
        ld_tail   = 1'b0;
        shift     = 1'b0;
        if (clear) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        ld_head   = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = FULL;
                        ld_tail   = 1'b1;
                    end else if (push && pop) begin
                        ld_head   = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt = ONE;
                        shift     = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr <= '0;
            head_addr  <= BASE_ADDR;
            tail_instr <= '0;
            tail_addr  <= BASE_ADDR;
        end else begin
            if (ld_head) begin
                head_instr <= word;
                head_addr  <= addr_cnt;
            end else if (shift) begin
                head_instr <= tail_instr;
                head_addr  <= tail_addr;
            end
            if (ld_tail) begin
                tail_instr <= word;
                tail_addr  <= addr_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_cnt <= BASE_ADDR;
        else if (clear)
            addr_cnt <= BASE_ADDR;
        else if (push)
            addr_cnt <= addr_cnt + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: directed test-plan words,
// backpressure, illegal/clear/reset cases and randomized traffic.
module tb_rv32_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    rv32_instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_alu_op (in_alu_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_addr   = 32'd0;
    int          m_cnt    = 0;
    bit          m_pend   = 1'b0;
    bit          popping  = 1'b0;
    bit          last_acc = 1'b0;
    bit          use_exp  = 1'b0;
    logic [31:0] exp_word = 32'd0;

    // funct3 per ALU op code 0..9
    int f3tab[10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};

    function automatic bit ref_legal(int kind, int op);
        if (kind <= 1 && op > 9) return 1'b0;
        if (kind == 1 && op == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_encode(int kind, int op, int rd,
                                               int rs1, int rs2, int imm);
        int f3;
        int f7;
        int iv;
        f3 = (op <= 9) ? f3tab[op] : 0;
        f7 = (op == 1 || op == 7) ? 32 : 0;
        case (kind)
            0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | (rd << 7) | 'h33;
            1: begin
                iv = imm;
                if (op == 5 || op == 6) iv = imm % 32;
                if (op == 7) iv = 'h400 + imm % 32;
                return (iv << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
            2: return (imm << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
            default: return ((imm / 32) << 25) | (rs2 << 20) | (rs1 << 15)
                            | (2 << 12) | ((imm % 32) << 7) | 'h23;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        popping = 1'b0;
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("err_pulse", 32'(err_pulse), 32'(m_pend));
            check("err_count", 32'(err_count), 32'(m_cnt));
            if (out_valid && q.size() != 0) begin
                check("out_instr", out_instr, q[0].instr);
                check("out_addr", out_addr, q[0].addr);
                if (out_ready) begin
                    void'(q.pop_front());
                    popping = 1'b1;
                end
            end
        end
    end

    task automatic model_reset();
        q.delete();
        m_addr = 32'd0;
        m_cnt  = 0;
        m_pend = 1'b0;
    endtask

    task automatic step();
        bit rdy;
        bit acc;
        bit lg;
        @(negedge clk);
        #1;
        rdy = rst_n && !clear && (q.size() + int'(popping) < 2);
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        lg  = ref_legal(int'(in_kind), int'(in_alu_op));
        last_acc = acc;
        if (clear) begin
            model_reset();
        end else begin
            m_pend = acc && !lg;
            if (acc && lg) begin
                q.push_back('{instr: use_exp ? exp_word :
                              ref_encode(int'(in_kind), int'(in_alu_op),
                                         int'(in_rd), int'(in_rs1),
                                         int'(in_rs2), int'(in_imm)),
                              addr: m_addr});
                m_addr = m_addr + 32'd4;
            end else if (acc && m_cnt < 255) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int kind, int op, int rd, int rs1, int rs2,
                           int imm);
        in_valid  = 1'b1;
        in_kind   = 2'(kind);
        in_alu_op = 4'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_imm    = 12'(imm);
    endtask

    task automatic wait_accept(string name);
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=not_accepted required=accepted",
                     name);
        end
        in_valid = 1'b0;
        use_exp  = 1'b0;
    endtask

    task automatic send(int kind, int op, int rd, int rs1, int rs2, int imm);
        set_req(kind, op, rd, rs1, rs2, imm);
        wait_accept("send");
    endtask

    task automatic send_exp(int kind, int op, int rd, int rs1, int rs2,
                            int imm, logic [31:0] w);
        use_exp  = 1'b1;
        exp_word = w;
        set_req(kind, op, rd, rs1, rs2, imm);
        wait_accept("send_exp");
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_addr"}, out_addr, 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        in_valid  = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        out_ready = 1'b1;
        send_exp(0, 0, 1, 2, 3, 0, 32'h003100B3);
        send_exp(0, 1, 1, 2, 3, 0, 32'h403100B3);
        send_exp(1, 0, 5, 0, 0, 'h7FF, 32'h7FF00293);
        send_exp(1, 7, 1, 1, 0, 'hFFF, 32'h41F0D093);
        send_exp(2, 0, 6, 2, 0, 4, 32'h00412303);
        send_exp(3, 0, 0, 2, 5, 8, 32'h00512423);
        repeat (3) step();

        do_clear();
        out_ready = 1'b0;
        send(0, 2, 7, 8, 9, 0);
        send(1, 4, 10, 11, 0, 'h5A5);
        set_req(3, 0, 0, 12, 13, 'hABC);
        repeat (3) step();
        out_ready = 1'b1;
        wait_accept("bp_third");
        repeat (4) step();

        do_clear();
        send(1, 1, 3, 4, 0, 'h10);
        send(0, 'hC, 3, 4, 5, 0);
        repeat (2) step();
        send(0, 3, 1, 1, 1, 0);
        repeat (3) step();

        out_ready = 1'b0;
        send(1, 1, 1, 1, 0, 0);
        send(2, 0, 2, 3, 0, 16);
        send(0, 8, 4, 5, 6, 0);
        do_clear();
        step();
        send(0, 9, 1, 2, 3, 0);
        out_ready = 1'b1;
        repeat (3) step();

        do_clear();
        for (int i = 0; i < 260; i++) send(1, 1, 0, 0, 0, 0);
        step();
        do_clear();

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 40) == 0;
            in_kind   = 2'($urandom);
            in_alu_op = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = 12'($urandom);
            step();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        out_ready = 1'b0;
        send(0, 4, 9, 8, 7, 0);
        send(1, 1, 2, 2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(2, 0, 1, 2, 0, 12);
        repeat (3) step();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
